rob_ring: RTL and testbench
===========================

# rob_ring

Parametrised circular reorder buffer for the out-of-order RV32I core. It sits between the decoder and the commit consumers: the register file, the memory controller, the branch predictor and the flush fan-out. Entries are allocated in program order and completed out of order by two writeback ports (ALU and load/store unit). At most one entry retires per cycle, and a mispredicted branch at the head triggers a single-edge flush.

## Interface
Parameters:
- IDX_W, 4, tag width; DEPTH = 1<<IDX_W entries
- XLEN, 32, data/address width
- REG_W, 5, architectural register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- alloc_valid  in  1  decoder requests an entry
- alloc_ready  out  1  entry available (comb)
- alloc_tag  out  IDX_W  tag given to the entry being allocated (= tail, comb)
- alloc_kind  in  2  0 reg-write, 1 store, 2 branch/jal/jalr, 3 no-op
- alloc_rd  in  REG_W  destination register
- alloc_pc  in  XLEN  instruction PC
- alloc_pred_pc  in  XLEN  predicted next PC
- wb0_valid / wb0_tag / wb0_value / wb0_next_pc  in  1/IDX_W/XLEN/XLEN  ALU result and resolved next PC
- wb1_valid / wb1_tag / wb1_value / wb1_addr  in  1/IDX_W/XLEN/XLEN  load/store result, store data and address
- store_ready  in  1  memory controller accepts a store commit this cycle
- commit_valid  out  1  retire pulse (reg)
- commit_kind / commit_tag / commit_rd / commit_value / commit_addr  out  2/IDX_W/REG_W/XLEN/XLEN  retired entry fields (reg)
- bp_valid / bp_pc / bp_taken  out  1/XLEN/1  predictor update on branch retire (reg)
- flush / flush_pc  out  1/XLEN  misprediction flush pulse and redirect PC (reg)
- count  out  IDX_W+1  occupancy (reg)

## Operation
- State: head, tail (IDX_W bits, wrap naturally mod DEPTH), count, and per entry: valid, done, kind, rd, pc, pred_pc, value, addr/next_pc.
- Reset: head=tail=count=0; all valid/done=0; every output register (commit_*, bp_*, flush, flush_pc) = 0.
- Allocate: alloc_valid && alloc_ready writes the entry at tail with valid=1, done=0, then tail+1. alloc_ready = (count < DEPTH).
- Writeback: wbN_valid with a valid entry sets done=1 and stores the payload. Writeback to an invalid entry is ignored. If wb0_tag == wb1_tag, both are valid, wb1 wins.
- Retire condition: head entry valid && done && (kind != store || store_ready). On retire, head+1, valid=0, and commit_valid plus fields are registered.
- Branch kind: bp_valid=1, bp_pc=pc, bp_taken=(next_pc != pc+4).
- Mispredict: a retiring branch with next_pc != pred_pc also registers flush=1 and flush_pc=next_pc. On that same edge, head=tail=count=0 and all valid/done=0. Allocation and writeback in that cycle are discarded.
- count update: +1 on alloc, −1 on retire, unchanged when both occur, 0 on flush.
- rdy low: no state changes; commit_valid, bp_valid and flush are registered as 0.

## Timing
- Allocation to earliest writeback: next cycle.
- Writeback at edge N → commit_valid high in the cycle after edge N+1, provided the entry is at the head. Minimum writeback-to-retire latency is 2 edges.
- Retire throughput: 1 per cycle.
- All output pulses last exactly one cycle.
- Full (count==DEPTH): alloc_ready=0 even if a retire occurs the same cycle; no same-cycle bypass.
- Empty: no retire; the head entry's done bit is ignored.
- Reset mid-flush or mid-retire overrides everything on that edge.

## Configuration
- ROB_QUERY_EN: when defined, adds two combinational operand lookup ports for dispatch.
  - Inputs: q0_tag, q1_tag (IDX_W).
  - Outputs: q0_ready, q1_ready (1) and q0_value, q1_value (XLEN).
  - qN_ready = valid && done of the entry; qN_value = its value.
  - A same-cycle wb0 or wb1 to the queried tag is forwarded: ready=1, value=writeback value, with wb1 taking priority.
- Without the macro, these ports are absent and no forwarding logic is built.

## Test plan
- Reset, allocate 16 entries with DEPTH=16 → alloc_ready=0, count=16, alloc_tag wraps to 0; retire one → next cycle alloc_ready=1.
- Allocate tags 0,1,2; write back 2, then 1, then 0 (values 0x22, 0x11, 0x00) → commits in order 0,1,2, one per cycle, with matching values.
- Store at head with done=1 and store_ready=0 for 3 cycles → no commit; store_ready=1 → commit_kind=1 and commit_addr equal to the address written back.
- Branch pc=0x100, pred_pc=0x104, next_pc=0x200 with 4 younger entries → flush=1, flush_pc=0x200, bp_taken=1, count=0 next cycle; a simultaneous alloc is dropped.
- wb0 and wb1 to the same tag 5 in one cycle (0xA, 0xB) → committed value 0xB; with ROB_QUERY_EN, q0_tag=5 in that cycle returns ready=1, value=0xB.
- rdy=0 for 2 cycles with a ready head → no commit and count unchanged; rdy=1 → commit on the next edge.

Source files
------------

// File: rtl/rob_ring.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback, single retire per cycle.
// Optional ROB_QUERY_EN adds two combinational operand lookup ports with writeback forwarding.
module rob_ring #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_tag,
  input  logic [1:0]       alloc_kind,
  input  logic [REG_W-1:0] alloc_rd,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic [XLEN-1:0]  alloc_pred_pc,
  input  logic             wb0_valid,
  input  logic [IDX_W-1:0] wb0_tag,
  input  logic [XLEN-1:0]  wb0_value,
  input  logic [XLEN-1:0]  wb0_next_pc,
  input  logic             wb1_valid,
  input  logic [IDX_W-1:0] wb1_tag,
  input  logic [XLEN-1:0]  wb1_value,
  input  logic [XLEN-1:0]  wb1_addr,
  input  logic             store_ready,
  output logic             commit_valid,
  output logic [1:0]       commit_kind,
  output logic [IDX_W-1:0] commit_tag,
  output logic [REG_W-1:0] commit_rd,
  output logic [XLEN-1:0]  commit_value,
  output logic [XLEN-1:0]  commit_addr,
  output logic             bp_valid,
  output logic [XLEN-1:0]  bp_pc,
  output logic             bp_taken,
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc,
  output logic [IDX_W:0]   count
`ifdef ROB_QUERY_EN
  ,
  input  logic [IDX_W-1:0] q0_tag,
  input  logic [IDX_W-1:0] q1_tag,
  output logic             q0_ready,
  output logic             q1_ready,
  output logic [XLEN-1:0]  q0_value,
  output logic [XLEN-1:0]  q1_value
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [1:0] KIND_STORE  = 2'd1;
  localparam logic [1:0] KIND_BRANCH = 2'd2;

  logic [IDX_W-1:0] head, tail;
  logic [DEPTH-1:0] ent_valid, ent_done;
  logic [1:0]       ent_kind  [DEPTH];
  logic [REG_W-1:0] ent_rd    [DEPTH];
  logic [XLEN-1:0]  ent_pc    [DEPTH];
  logic [XLEN-1:0]  ent_pred  [DEPTH];
  logic [XLEN-1:0]  ent_value [DEPTH];
  // Resolved next PC for branches, memory address for loads/stores.
  logic [XLEN-1:0]  ent_aux   [DEPTH];

  logic alloc_fire, wb0_hit, wb1_hit, retire, head_branch, mispredict;

  always_comb begin
    alloc_ready = (count != (IDX_W+1)'(DEPTH));
    alloc_tag   = tail;
    alloc_fire  = rdy && alloc_valid && alloc_ready;
    wb0_hit     = rdy && wb0_valid && ent_valid[wb0_tag];
    wb1_hit     = rdy && wb1_valid && ent_valid[wb1_tag];
    head_branch = (ent_kind[head] == KIND_BRANCH);
    retire      = rdy && (count != '0) && ent_valid[head] && ent_done[head] &&
                  ((ent_kind[head] != KIND_STORE) || store_ready);
    mispredict  = retire && head_branch && (ent_aux[head] != ent_pred[head]);
  end

  // Control state and registered commit / predictor / flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ent_valid    <= '0;
      ent_done     <= '0;
      commit_valid <= 1'b0;
      commit_kind  <= '0;
      commit_tag   <= '0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_addr  <= '0;
      bp_valid     <= 1'b0;
      bp_pc        <= '0;
      bp_taken     <= 1'b0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else if (rdy) begin
      commit_valid <= retire;
      bp_valid     <= retire && head_branch;
      flush        <= mispredict;
      if (retire) begin
        commit_kind  <= ent_kind[head];
        commit_tag   <= head;
        commit_rd    <= ent_rd[head];
        commit_value <= ent_value[head];
        commit_addr  <= ent_aux[head];
        if (head_branch) begin
          bp_pc    <= ent_pc[head];
          bp_taken <= (ent_aux[head] != (ent_pc[head] + XLEN'(4)));
        end
      end
      if (mispredict) begin
        flush_pc  <= ent_aux[head];
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        ent_valid <= '0;
        ent_done  <= '0;
      end else begin
        if (alloc_fire) begin
          ent_valid[tail] <= 1'b1;
          ent_done[tail]  <= 1'b0;
          tail            <= tail + IDX_W'(1);
        end
        if (wb0_hit) ent_done[wb0_tag] <= 1'b1;
        if (wb1_hit) ent_done[wb1_tag] <= 1'b1;
        if (retire) begin
          ent_valid[head] <= 1'b0;
          ent_done[head]  <= 1'b0;
          head            <= head + IDX_W'(1);
        end
        case ({alloc_fire, retire})
          2'b10:   count <= count + (IDX_W+1)'(1);
          2'b01:   count <= count - (IDX_W+1)'(1);
          default: count <= count;
        endcase
      end
    end else begin
      commit_valid <= 1'b0;
      bp_valid     <= 1'b0;
      flush        <= 1'b0;
    end
  end

  // Entry payload; stale data is harmless because valid/done gate every use.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      ent_kind[tail] <= alloc_kind;
      ent_rd[tail]   <= alloc_rd;
      ent_pc[tail]   <= alloc_pc;
      ent_pred[tail] <= alloc_pred_pc;
    end
    if (wb0_hit) begin
      ent_value[wb0_tag] <= wb0_value;
      ent_aux[wb0_tag]   <= wb0_next_pc;
    end
    if (wb1_hit) begin
      ent_value[wb1_tag] <= wb1_value;
      ent_aux[wb1_tag]   <= wb1_addr;
    end
  end

`ifdef ROB_QUERY_EN
  // Operand lookup with same-cycle writeback forwarding; wb1 has priority.
  always_comb begin
    q0_ready = ent_valid[q0_tag] && ent_done[q0_tag];
    q0_value = ent_value[q0_tag];
    if (wb0_valid && (wb0_tag == q0_tag) && ent_valid[q0_tag]) begin
      q0_ready = 1'b1;
      q0_value = wb0_value;
    end
    if (wb1_valid && (wb1_tag == q0_tag) && ent_valid[q0_tag]) begin
      q0_ready = 1'b1;
      q0_value = wb1_value;
    end
    q1_ready = ent_valid[q1_tag] && ent_done[q1_tag];
    q1_value = ent_value[q1_tag];
    if (wb0_valid && (wb0_tag == q1_tag) && ent_valid[q1_tag]) begin
      q1_ready = 1'b1;
      q1_value = wb0_value;
    end
    if (wb1_valid && (wb1_tag == q1_tag) && ent_valid[q1_tag]) begin
      q1_ready = 1'b1;
      q1_value = wb1_value;
    end
  end
`endif

endmodule

// File: tb/tb_rob_ring.sv
// Self-checking bench for rob_ring: directed scenarios plus randomized traffic
// against a program-order queue model of the reorder buffer.
module tb_rob_ring;

  logic        clk = 1'b0;
  logic        rst, rdy, alloc_valid, wb0_valid, wb1_valid, store_ready;
  logic [1:0]  alloc_kind;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc, alloc_pred_pc, wb0_value, wb0_next_pc, wb1_value, wb1_addr;
  logic [3:0]  wb0_tag, wb1_tag;
  logic        alloc_ready, commit_valid, bp_valid, bp_taken, flush;
  logic [3:0]  alloc_tag, commit_tag;
  logic [1:0]  commit_kind;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, commit_addr, bp_pc, flush_pc;
  logic [4:0]  count;
`ifdef ROB_QUERY_EN
  logic [3:0]  q0_tag, q1_tag;
  logic        q0_ready, q1_ready;
  logic [31:0] q0_value, q1_value;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_ring dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_kind(alloc_kind), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_pred_pc(alloc_pred_pc),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value), .wb0_next_pc(wb0_next_pc),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value), .wb1_addr(wb1_addr),
    .store_ready(store_ready),
    .commit_valid(commit_valid), .commit_kind(commit_kind), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_addr(commit_addr),
    .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .flush(flush), .flush_pc(flush_pc), .count(count)
`ifdef ROB_QUERY_EN
    , .q0_tag(q0_tag), .q1_tag(q1_tag), .q0_ready(q0_ready), .q1_ready(q1_ready),
    .q0_value(q0_value), .q1_value(q1_value)
`endif
  );

  // Reference model: in-flight instructions kept in program order.
  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] pc, pred, value, aux;
    bit          done;
  } ent_t;

  ent_t rob[$];
  int   mtail;
  bit          e_commit_valid, e_bp_valid, e_bp_taken, e_flush;
  logic [1:0]  e_commit_kind;
  logic [3:0]  e_commit_tag;
  logic [4:0]  e_commit_rd;
  logic [31:0] e_commit_value, e_commit_addr, e_bp_pc, e_flush_pc;
  int          e_count;

  task automatic model_step();
    ent_t h, t;
    bit ret, mis, alloc_ok;
    if (rst) begin
      rob.delete(); mtail = 0; e_count = 0;
      e_commit_valid = 0; e_bp_valid = 0; e_flush = 0;
      return;
    end
    if (!rdy) begin
      e_commit_valid = 0; e_bp_valid = 0; e_flush = 0;
      return;
    end
    ret = 0; mis = 0;
    alloc_ok = alloc_valid && (rob.size() < 16);
    if (rob.size() > 0) begin
      h = rob[0];
      ret = h.done && (h.kind != 2'd1 || store_ready);
    end
    e_commit_valid = ret;
    e_bp_valid = ret && (h.kind == 2'd2);
    e_flush = 0;
    if (ret) begin
      e_commit_kind = h.kind; e_commit_tag = h.tag; e_commit_rd = h.rd;
      e_commit_value = h.value; e_commit_addr = h.aux;
      if (h.kind == 2'd2) begin
        e_bp_pc = h.pc;
        e_bp_taken = (h.aux != h.pc + 32'd4);
        mis = (h.aux != h.pred);
      end
    end
    if (mis) begin
      e_flush = 1; e_flush_pc = h.aux;
      rob.delete(); mtail = 0;
    end else begin
      for (int i = 0; i < rob.size(); i++)
        if (wb0_valid && rob[i].tag == wb0_tag) begin
          t = rob[i]; t.done = 1; t.value = wb0_value; t.aux = wb0_next_pc; rob[i] = t;
        end
      for (int i = 0; i < rob.size(); i++)
        if (wb1_valid && rob[i].tag == wb1_tag) begin
          t = rob[i]; t.done = 1; t.value = wb1_value; t.aux = wb1_addr; rob[i] = t;
        end
      if (ret) void'(rob.pop_front());
      if (alloc_ok) begin
        t.tag = 4'(mtail); t.kind = alloc_kind; t.rd = alloc_rd; t.pc = alloc_pc;
        t.pred = alloc_pred_pc; t.value = '0; t.aux = '0; t.done = 0;
        rob.push_back(t);
        mtail = (mtail + 1) % 16;
      end
    end
    e_count = rob.size();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rdy = 1; alloc_valid = 0; alloc_kind = 0; alloc_rd = 0; alloc_pc = 0; alloc_pred_pc = 0;
    wb0_valid = 0; wb0_tag = 0; wb0_value = 0; wb0_next_pc = 0;
    wb1_valid = 0; wb1_tag = 0; wb1_value = 0; wb1_addr = 0; store_ready = 1;
`ifdef ROB_QUERY_EN
    q0_tag = 0; q1_tag = 0;
`endif
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic alloc_one(input logic [1:0] kind, input logic [4:0] rd,
                           input logic [31:0] pc, input logic [31:0] pred);
    alloc_valid = 1; alloc_kind = kind; alloc_rd = rd; alloc_pc = pc; alloc_pred_pc = pred;
    tick();
    alloc_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (commit_valid !== 1'b0 || bp_valid !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got=%b%b%b exp=000", commit_valid, bp_valid, flush); end
    checks++; if (commit_value !== 32'd0 || flush_pc !== 32'd0 || bp_pc !== 32'd0) begin
      errors++; $display("FAIL reset_fields got=%h/%h/%h exp=0", commit_value, flush_pc, bp_pc); end
    checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
      errors++; $display("FAIL reset_alloc got=%b/%0d exp=1/0", alloc_ready, alloc_tag); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) alloc_one(2'd0, 5'(i), 32'(i * 4), 32'(i * 4 + 4));
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", count); end
    checks++; if (alloc_ready !== 1'b0 || alloc_tag !== 4'd0) begin
      errors++; $display("FAIL full_alloc got=%b/%0d exp=0/0", alloc_ready, alloc_tag); end
    alloc_one(2'd0, 5'd1, 32'h40, 32'h44);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_overalloc got=%0d exp=16", count); end
    wb0_valid = 1; wb0_tag = 0; wb0_value = 32'h5; wb0_next_pc = 32'h4;
    tick();
    wb0_valid = 0;
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'd0) begin
      errors++; $display("FAIL full_retire got=%b/%0d exp=1/0", commit_valid, commit_tag); end
    checks++; if (alloc_ready !== 1'b1 || count !== 5'd15) begin
      errors++; $display("FAIL full_ready_after got=%b/%0d exp=1/15", alloc_ready, count); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] vals [3];
    vals[0] = 32'h00; vals[1] = 32'h11; vals[2] = 32'h22;
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(2'd0, 5'(i + 1), 32'(i * 4), 32'(i * 4 + 4));
    for (int i = 2; i >= 0; i--) begin
      wb0_valid = 1; wb0_tag = 4'(i); wb0_value = vals[i]; wb0_next_pc = 32'(i * 4 + 4);
      tick();
      checks++; if (commit_valid !== 1'b0) begin
        errors++; $display("FAIL ooo_early_commit tag=%0d got=1 exp=0", i); end
    end
    wb0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'(i) || commit_value !== vals[i] ||
                    commit_rd !== 5'(i + 1)) begin
        errors++; $display("FAIL ooo_commit%0d got=%b/%0d/%h/%0d exp=1/%0d/%h/%0d",
                           i, commit_valid, commit_tag, commit_value, commit_rd, i, vals[i], i + 1); end
    end
    tick();
    checks++; if (commit_valid !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL ooo_drain got=%b/%0d exp=0/0", commit_valid, count); end
  endtask

  task automatic test_store();
    do_reset();
    alloc_one(2'd1, 5'd0, 32'h80, 32'h84);
    wb1_valid = 1; wb1_tag = 0; wb1_value = 32'h55; wb1_addr = 32'h1000;
    store_ready = 0;
    tick();
    wb1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (commit_valid !== 1'b0) begin
        errors++; $display("FAIL store_blocked cyc=%0d got=1 exp=0", i); end
    end
    store_ready = 1;
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_kind !== 2'd1 || commit_addr !== 32'h1000 ||
                  commit_value !== 32'h55) begin
      errors++; $display("FAIL store_commit got=%b/%0d/%h/%h exp=1/1/1000/55",
                         commit_valid, commit_kind, commit_addr, commit_value); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_one(2'd2, 5'd1, 32'h100, 32'h104);
    for (int i = 0; i < 4; i++) alloc_one(2'd0, 5'(i + 2), 32'(32'h104 + i * 4), 32'(32'h108 + i * 4));
    wb0_valid = 1; wb0_tag = 0; wb0_value = 32'h104; wb0_next_pc = 32'h200;
    tick();
    wb0_valid = 0;
    alloc_one(2'd0, 5'd9, 32'h300, 32'h304);
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h200) begin
      errors++; $display("FAIL flush_pulse got=%b/%h exp=1/200", flush, flush_pc); end
    checks++; if (bp_valid !== 1'b1 || bp_taken !== 1'b1 || bp_pc !== 32'h100) begin
      errors++; $display("FAIL flush_bp got=%b/%b/%h exp=1/1/100", bp_valid, bp_taken, bp_pc); end
    checks++; if (count !== 5'd0 || alloc_tag !== 4'd0) begin
      errors++; $display("FAIL flush_clear got=%0d/%0d exp=0/0", count, alloc_tag); end
    tick();
    checks++; if (flush !== 1'b0 || count !== 5'd0 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL flush_after got=%b/%0d/%b exp=0/0/0", flush, count, commit_valid); end
  endtask

  task automatic test_same_tag();
    bit seen = 0;
    logic [31:0] got = 0;
    do_reset();
    for (int i = 0; i < 6; i++) alloc_one(2'd0, 5'(i), 32'(i * 4), 32'(i * 4 + 4));
    wb0_valid = 1; wb0_tag = 5; wb0_value = 32'hA; wb0_next_pc = 32'h18;
    wb1_valid = 1; wb1_tag = 5; wb1_value = 32'hB; wb1_addr = 32'h18;
`ifdef ROB_QUERY_EN
    q0_tag = 5; q1_tag = 4;
    #1;
    checks++; if (q0_ready !== 1'b1 || q0_value !== 32'hB) begin
      errors++; $display("FAIL query_fwd got=%b/%h exp=1/b", q0_ready, q0_value); end
    checks++; if (q1_ready !== 1'b0) begin
      errors++; $display("FAIL query_notready got=%b exp=0", q1_ready); end
`endif
    tick();
    wb1_valid = 0;
    for (int i = 0; i < 5; i++) begin
      wb0_valid = 1; wb0_tag = 4'(i); wb0_value = 32'(i); wb0_next_pc = 32'(i * 4 + 4);
      tick();
    end
    wb0_valid = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (commit_valid === 1'b1 && commit_tag === 4'd5) begin seen = 1; got = commit_value; end
    end
    checks++; if (!seen || got !== 32'hB) begin
      errors++; $display("FAIL same_tag_commit seen=%0d got=%h exp=b", seen, got); end
  endtask

  task automatic test_rdy();
    do_reset();
    alloc_one(2'd0, 5'd3, 32'h10, 32'h14);
    wb0_valid = 1; wb0_tag = 0; wb0_value = 32'h77; wb0_next_pc = 32'h14;
    tick();
    wb0_valid = 0;
    rdy = 0; alloc_valid = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (commit_valid !== 1'b0 || count !== 5'd1) begin
        errors++; $display("FAIL rdy_freeze cyc=%0d got=%b/%0d exp=0/1", i, commit_valid, count); end
    end
    rdy = 1; alloc_valid = 0;
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_value !== 32'h77 || count !== 5'd0) begin
      errors++; $display("FAIL rdy_resume got=%b/%h/%0d exp=1/77/0", commit_valid, commit_value, count); end
  endtask

  task automatic test_random();
    int r, idx;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rdy = ($urandom_range(0, 9) != 0);
      store_ready = 1'($urandom_range(0, 1));
      alloc_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      alloc_kind = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
      alloc_rd = 5'($urandom);
      alloc_pc = 32'($urandom_range(0, 1023)) << 2;
      alloc_pred_pc = ($urandom_range(0, 3) != 0) ? alloc_pc + 32'd4 : 32'h400;
      wb0_valid = 1'($urandom_range(0, 1));
      wb1_valid = ($urandom_range(0, 3) == 0);
      wb0_value = $urandom; wb1_value = $urandom; wb1_addr = $urandom;
      if (rob.size() > 0 && $urandom_range(0, 4) != 0) begin
        idx = $urandom_range(0, rob.size() - 1);
        wb0_tag = rob[idx].tag;
        wb0_next_pc = ($urandom_range(0, 4) != 0) ? rob[idx].pred : 32'h800;
        idx = $urandom_range(0, rob.size() - 1);
        wb1_tag = ($urandom_range(0, 3) == 0) ? wb0_tag : rob[idx].tag;
      end else begin
        wb0_tag = 4'($urandom); wb1_tag = 4'($urandom); wb0_next_pc = $urandom;
      end
      #1;
      checks++; if (alloc_ready !== (rob.size() < 16) || alloc_tag !== 4'(mtail)) begin
        errors++; $display("FAIL rnd_alloc cyc=%0d got=%b/%0d exp=%b/%0d",
                           cyc, alloc_ready, alloc_tag, rob.size() < 16, mtail); end
      tick();
      checks++; if (commit_valid !== e_commit_valid || bp_valid !== e_bp_valid ||
                    flush !== e_flush || count !== 5'(e_count)) begin
        errors++; $display("FAIL rnd_ctl cyc=%0d got=%b%b%b/%0d exp=%b%b%b/%0d", cyc,
                           commit_valid, bp_valid, flush, count,
                           e_commit_valid, e_bp_valid, e_flush, e_count); end
      if (e_commit_valid) begin
        checks++; if (commit_kind !== e_commit_kind || commit_tag !== e_commit_tag ||
                      commit_rd !== e_commit_rd || commit_value !== e_commit_value ||
                      commit_addr !== e_commit_addr) begin
          errors++; $display("FAIL rnd_commit cyc=%0d got=%0d/%0d/%0d/%h/%h exp=%0d/%0d/%0d/%h/%h", cyc,
                             commit_kind, commit_tag, commit_rd, commit_value, commit_addr,
                             e_commit_kind, e_commit_tag, e_commit_rd, e_commit_value, e_commit_addr); end
      end
      if (e_bp_valid) begin
        checks++; if (bp_pc !== e_bp_pc || bp_taken !== e_bp_taken) begin
          errors++; $display("FAIL rnd_bp cyc=%0d got=%h/%b exp=%h/%b",
                             cyc, bp_pc, bp_taken, e_bp_pc, e_bp_taken); end
      end
      if (e_flush) begin
        checks++; if (flush_pc !== e_flush_pc) begin
          errors++; $display("FAIL rnd_flush_pc cyc=%0d got=%h exp=%h", cyc, flush_pc, e_flush_pc); end
      end
    end
    set_idle();
  endtask

  initial begin
    rst = 1;
    set_idle();
    test_reset();
    test_full();
    test_out_of_order();
    test_store();
    test_flush();
    test_same_tag();
    test_rdy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
